// File: rtl/opb_arb_pkg.sv
// Shared types and constants for the OPB round-robin arbiter.
// Optional parked-grant mode is selected with the OPB_ARB_PARK_EN macro.
package opb_arb_pkg;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_BUSY = 1'b1
    } opb_arb_state_e;

    localparam int unsigned OPB_ARB_MAX_MASTERS = 8;
    localparam int unsigned OPB_ARB_DEF_MASTERS = 4;
    localparam int unsigned OPB_ARB_DEF_TIMEOUT = 16;

    // Bits needed to index n items; never narrower than one bit.
    function automatic int unsigned idx_width(input int unsigned n);
        int unsigned w;
        w = 1;
        while ((32'd1 << w) < n) begin
            w = w + 1;
        end
        return w;
    endfunction

endpackage

// File: rtl/opb_rr_pick.sv
// Combinational round-robin priority encoder: the search starts one past
// last_i and wraps, so the most recent winner has the lowest priority.
module opb_rr_pick
    import opb_arb_pkg::*;
#(
    parameter  int unsigned C_NUM_MASTERS = OPB_ARB_DEF_MASTERS,
    localparam int unsigned IW            = idx_width(C_NUM_MASTERS)
) (
    input  logic [C_NUM_MASTERS-1:0] req_i,
    input  logic [IW-1:0]            last_i,
    output logic [IW-1:0]            winner_o,
    output logic                     valid_o
);

    logic [IW-1:0] idx_s;

    // Walk from farthest to nearest so the nearest requester is written last.
    always_comb begin
        winner_o = last_i;
        valid_o  = |req_i;
        idx_s    = last_i;
        for (int i = int'(C_NUM_MASTERS); i >= 1; i--) begin
            idx_s    = IW'((int'(last_i) + i) % int'(C_NUM_MASTERS));
            winner_o = req_i[idx_s] ? idx_s : winner_o;
        end
    end

endmodule

// File: rtl/opb_rr_arbiter.sv
// OPB bus arbiter: round-robin grant, transfer tracking, timeout and lock.
// Define OPB_ARB_PARK_EN to park the last grant on the bus while idle.
module opb_rr_arbiter
    import opb_arb_pkg::*;
#(
    parameter  int unsigned C_NUM_MASTERS = OPB_ARB_DEF_MASTERS,
    parameter  int unsigned C_TIMEOUT     = OPB_ARB_DEF_TIMEOUT,
    localparam int unsigned IW            = idx_width(C_NUM_MASTERS),
    localparam int unsigned TW            = idx_width(C_TIMEOUT)
) (
    input  logic                     OPB_Clk,
    input  logic                     OPB_Rst,
    input  logic [C_NUM_MASTERS-1:0] M_request,
    input  logic [C_NUM_MASTERS-1:0] M_busLock,
    input  logic                     Sl_xferAck,
    input  logic                     Sl_errAck,
    input  logic                     Sl_retry,
    input  logic                     Sl_toutSup,
    output logic [C_NUM_MASTERS-1:0] OPB_MGrant,
    output logic                     OPB_select,
    output logic                     OPB_timeout,
    output logic [IW-1:0]            arb_last
);

    localparam logic [TW-1:0] CNT_MAX = TW'(C_TIMEOUT - 1);
    localparam logic [TW-1:0] CNT_ONE = TW'(1);
    localparam logic [C_NUM_MASTERS-1:0] ONE_HOT0 = C_NUM_MASTERS'(1);

    opb_arb_state_e           state_q, state_d;
    logic [C_NUM_MASTERS-1:0] grant_q, grant_d;
    logic                     select_q, select_d;
    logic                     tout_q, tout_d;
    logic [IW-1:0]            last_q, last_d;
    logic [TW-1:0]            cnt_q, cnt_d;

    logic [IW-1:0]            pick_idx_s;
    logic                     pick_valid_s;
    logic                     ack_s;
    logic                     gnt_req_s;
    logic                     gnt_lock_s;
    logic [C_NUM_MASTERS-1:0] idle_grant_s;
    logic                     park_hit_s;

    opb_rr_pick #(
        .C_NUM_MASTERS (C_NUM_MASTERS)
    ) u_pick (
        .req_i    (M_request),
        .last_i   (last_q),
        .winner_o (pick_idx_s),
        .valid_o  (pick_valid_s)
    );

    assign ack_s      = Sl_xferAck | Sl_errAck | Sl_retry;
    assign gnt_req_s  = |(M_request & grant_q);
    assign gnt_lock_s = |(M_busLock & grant_q);

`ifdef OPB_ARB_PARK_EN
    // A parked master that is the sole requester starts its transfer at once.
    assign idle_grant_s = ONE_HOT0 << last_q;
    assign park_hit_s   = (grant_q != '0) && (M_request == grant_q);
`else
    assign idle_grant_s = '0;
    assign park_hit_s   = 1'b0;
`endif

    // Next-state, grant, counter and timeout decisions.
    always_comb begin
        state_d  = state_q;
        grant_d  = grant_q;
        select_d = select_q;
        tout_d   = 1'b0;
        last_d   = last_q;
        cnt_d    = cnt_q;
        case (state_q)
            ST_IDLE: begin
                if (park_hit_s) begin
                    state_d  = ST_BUSY;
                    select_d = 1'b1;
                    cnt_d    = '0;
                end else if (pick_valid_s) begin
                    state_d  = ST_BUSY;
                    grant_d  = ONE_HOT0 << pick_idx_s;
                    select_d = 1'b1;
                    last_d   = pick_idx_s;
                    cnt_d    = '0;
                end else begin
                    select_d = 1'b0;
                end
            end
            ST_BUSY: begin
                if (ack_s) begin
                    if (gnt_lock_s && gnt_req_s) begin
                        cnt_d = '0;
                    end else begin
                        state_d  = ST_IDLE;
                        grant_d  = idle_grant_s;
                        select_d = 1'b0;
                    end
                end else if (!gnt_req_s) begin
                    state_d  = ST_IDLE;
                    grant_d  = idle_grant_s;
                    select_d = 1'b0;
                end else if (Sl_toutSup) begin
                    cnt_d = cnt_q;
                end else if (cnt_q == CNT_MAX) begin
                    state_d  = ST_IDLE;
                    grant_d  = idle_grant_s;
                    select_d = 1'b0;
                    tout_d   = 1'b1;
                end else begin
                    cnt_d = cnt_q + CNT_ONE;
                end
            end
            default: begin
                state_d  = ST_IDLE;
                grant_d  = '0;
                select_d = 1'b0;
            end
        endcase
    end

    // State and output registers; last starts at the top so master 0 wins first.
    always_ff @(posedge OPB_Clk or posedge OPB_Rst) begin
        if (OPB_Rst) begin
            state_q  <= ST_IDLE;
            grant_q  <= '0;
            select_q <= 1'b0;
            tout_q   <= 1'b0;
            last_q   <= IW'(C_NUM_MASTERS - 1);
            cnt_q    <= '0;
        end else begin
            state_q  <= state_d;
            grant_q  <= grant_d;
            select_q <= select_d;
            tout_q   <= tout_d;
            last_q   <= last_d;
            cnt_q    <= cnt_d;
        end
    end

    assign OPB_MGrant  = grant_q;
    assign OPB_select  = select_q;
    assign OPB_timeout = tout_q;
    assign arb_last    = last_q;

endmodule

// File: tb/tb_opb_rr_arbiter.sv
// Directed self-checking bench for opb_rr_arbiter (4 masters, timeout 16).
module tb_opb_rr_arbiter;

    logic       clk;
    logic       rst;
    logic [3:0] req;
    logic [3:0] lock;
    logic       xack;
    logic       eack;
    logic       retry;
    logic       tsup;
    logic [3:0] gnt;
    logic       sel;
    logic       tout;
    logic [1:0] last;

    int n_checks;
    int n_errors;

    opb_rr_arbiter #(
        .C_NUM_MASTERS (4),
        .C_TIMEOUT     (16)
    ) dut (
        .OPB_Clk     (clk),
        .OPB_Rst     (rst),
        .M_request   (req),
        .M_busLock   (lock),
        .Sl_xferAck  (xack),
        .Sl_errAck   (eack),
        .Sl_retry    (retry),
        .Sl_toutSup  (tsup),
        .OPB_MGrant  (gnt),
        .OPB_select  (sel),
        .OPB_timeout (tout),
        .arb_last    (last)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_checks = n_checks + 1;
        if (act !== exp) begin
            n_errors = n_errors + 1;
            $display("FAIL %s: got %0h expected %0h", tag, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        n_checks = 0;
        n_errors = 0;
        rst = 1'b1; req = 4'b0000; lock = 4'b0000;
        xack = 1'b0; eack = 1'b0; retry = 1'b0; tsup = 1'b0;
        tick(); tick();
        check("rst_grant", {28'd0, gnt}, 32'h0);
        check("rst_select", {31'd0, sel}, 32'h0);
        check("rst_timeout", {31'd0, tout}, 32'h0);
        check("rst_last", {30'd0, last}, 32'h3);
        rst = 1'b0;
        tick();

        // Round robin between masters 0 and 2; ack types rotate.
        req = 4'b0101;
        for (int k = 0; k < 4; k++) begin
            tick();
            check("rr_grant", {28'd0, gnt}, (k % 2 == 0) ? 32'h1 : 32'h4);
            check("rr_select", {31'd0, sel}, 32'h1);
            xack = (k == 0) || (k == 3);
            eack = (k == 1);
            retry = (k == 2);
            tick();
            check("rr_release", {28'd0, gnt}, 32'h0);
            xack = 1'b0; eack = 1'b0; retry = 1'b0;
        end
        req = 4'b0000;
        tick();
        check("rr_idle", {28'd0, gnt}, 32'h0);
        check("rr_last", {30'd0, last}, 32'h2);

        // Locked master 1 keeps the grant across three transfers.
        req = 4'b0010; lock = 4'b0010;
        tick();
        check("lk_grant", {28'd0, gnt}, 32'h2);
        for (int t = 0; t < 3; t++) begin
            tick();
            check("lk_hold", {28'd0, gnt}, 32'h2);
            if (t == 2) lock = 4'b0000;
            xack = 1'b1;
            tick();
            check("lk_after_ack", {28'd0, gnt}, (t < 2) ? 32'h2 : 32'h0);
            check("lk_select", {31'd0, sel}, (t < 2) ? 32'h1 : 32'h0);
            xack = 1'b0;
        end

        // Master 3 never acked: timeout 16 cycles after the grant edge.
        req = 4'b1000;
        tick();
        check("to_grant", {28'd0, gnt}, 32'h8);
        for (int i = 1; i <= 16; i++) begin
            tick();
            check("to_pulse", {31'd0, tout}, (i == 16) ? 32'h1 : 32'h0);
            check("to_gnt", {28'd0, gnt}, (i == 16) ? 32'h0 : 32'h8);
        end
        // Pulse is one cycle; master 3 is re-granted after the dead cycle.
        tick();
        check("to_one_cycle", {31'd0, tout}, 32'h0);
        check("to_regrant", {28'd0, gnt}, 32'h8);

        // Five suppressed cycles push the timeout to cycle 21.
        tsup = 1'b1;
        for (int i = 1; i <= 21; i++) begin
            tick();
            if (i == 5) tsup = 1'b0;
            check("sup_pulse", {31'd0, tout}, (i == 21) ? 32'h1 : 32'h0);
        end
        check("sup_gnt", {28'd0, gnt}, 32'h0);

        // Ack coincident with counter 15 beats the timeout.
        tick();
        check("ack15_grant", {28'd0, gnt}, 32'h8);
        for (int i = 1; i <= 15; i++) begin
            tick();
        end
        check("ack15_pre", {31'd0, tout}, 32'h0);
        xack = 1'b1;
        tick();
        check("ack15_tout", {31'd0, tout}, 32'h0);
        check("ack15_gnt", {28'd0, gnt}, 32'h0);
        xack = 1'b0; req = 4'b0000;
        tick();
        check("ack15_late", {31'd0, tout}, 32'h0);

        // Master 2 aborts by dropping its request.
        req = 4'b0100;
        tick();
        check("ab_grant", {28'd0, gnt}, 32'h4);
        tick(); tick(); tick();
        req = 4'b0000;
        tick();
        check("ab_gnt", {28'd0, gnt}, 32'h0);
        check("ab_tout", {31'd0, tout}, 32'h0);
        check("ab_select", {31'd0, sel}, 32'h0);
        tick();
        check("ab_tout_late", {31'd0, tout}, 32'h0);

        // Asynchronous reset during a grant, then master 0 wins among all.
        req = 4'b0010;
        tick();
        check("ar_grant", {28'd0, gnt}, 32'h2);
        #2 rst = 1'b1;
        #1;
        check("ar_gnt", {28'd0, gnt}, 32'h0);
        check("ar_select", {31'd0, sel}, 32'h0);
        check("ar_last", {30'd0, last}, 32'h3);
        req = 4'b1111;
        tick();
        rst = 1'b0;
        tick();
        check("ar_first", {28'd0, gnt}, 32'h1);
        check("ar_last0", {30'd0, last}, 32'h0);

        // Master 1 completes; idle grant depends on park mode.
        xack = 1'b1; req = 4'b0000;
        tick();
        xack = 1'b0; req = 4'b0010;
        tick();
        check("pk_grant", {28'd0, gnt}, 32'h2);
        xack = 1'b1; req = 4'b0000;
        tick();
        xack = 1'b0;
        check("pk_sel_rel", {31'd0, sel}, 32'h0);
`ifdef OPB_ARB_PARK_EN
        check("pk_park", {28'd0, gnt}, 32'h2);
        tick();
        check("pk_park_hold", {28'd0, gnt}, 32'h2);
`else
        check("pk_park", {28'd0, gnt}, 32'h0);
        tick();
        check("pk_park_hold", {28'd0, gnt}, 32'h0);
`endif
        req = 4'b0010;
        tick();
        check("pk_resel", {31'd0, sel}, 32'h1);
        check("pk_regrant", {28'd0, gnt}, 32'h2);
        xack = 1'b1; req = 4'b0000;
        tick();
        xack = 1'b0;
        check("pk_done", {31'd0, sel}, 32'h0);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule

// File: doc/opb_rr_arbiter.md
# opb_rr_arbiter

Round-robin arbiter that shares the single OPB register bus between up to C_NUM_MASTERS requesters. Examples of requesters are the PPC bridge and debug/DMA engines that read status registers such as the simulink2ppc status blocks. The arbiter issues one-hot grants, tracks each transfer until a slave acknowledge, enforces a bus timeout, and supports bus locking for back-to-back accesses. It sits between the OPB masters and the OPB slave address decode.

## Interface
- C_NUM_MASTERS, 4, number of requesters (2..8)
- C_TIMEOUT, 16, cycles in BUSY without acknowledge before timeout (4..256)
- OPB_Clk  in  1  bus clock; all logic on the rising edge
- OPB_Rst  in  1  asynchronous, active-high reset
- M_request  in  C_NUM_MASTERS  per-master bus request, level
- M_busLock  in  C_NUM_MASTERS  per-master lock; holds the grant across transfers
- Sl_xferAck  in  1  OR of slave transfer acknowledges
- Sl_errAck  in  1  OR of slave error acknowledges
- Sl_retry  in  1  OR of slave retries
- Sl_toutSup  in  1  OR of slave timeout suppress
- OPB_MGrant  out  C_NUM_MASTERS  one-hot grant, registered
- OPB_select  out  1  a granted transfer is in progress, registered
- OPB_timeout  out  1  one-cycle pulse on bus timeout, registered
- arb_last  out  clog2(C_NUM_MASTERS)  index of the most recently granted master

## Operation
- **States:** IDLE and BUSY.
- **Reset:** state is IDLE. OPB_MGrant=0, OPB_select=0, OPB_timeout=0, arb_last=C_NUM_MASTERS-1, so master 0 has first priority. The timeout counter is 0.
- **IDLE:**
  - If any M_request bit is high, pick the winner by round-robin. The search starts at arb_last+1 and wraps modulo C_NUM_MASTERS.
  - Next cycle: OPB_MGrant=onehot(winner), OPB_select=1, arb_last=winner, state BUSY, counter=0.
- **BUSY, ack-class event:** an ack-class event is any of Sl_xferAck, Sl_errAck or Sl_retry.
  - If M_busLock and M_request of the granted master are both high, stay in BUSY, keep the grant and clear the counter.
  - Otherwise go to IDLE next cycle with OPB_MGrant=0 and OPB_select=0.
  - errAck and retry are treated identically to xferAck. The arbiter does not reissue a retried transfer.
- **BUSY, granted master drops M_request without an ack:** abort. Go to IDLE next cycle and release the grant. OPB_timeout is not asserted.
- **BUSY, timeout counter:** the counter increments each cycle unless Sl_toutSup is high, in which case it holds.
  - When the counter equals C_TIMEOUT-1 and there is no ack-class event in that cycle: next cycle OPB_timeout=1 for exactly one cycle, the grant is released, and state is IDLE.
- **Simultaneous ack and timeout in the same cycle:** the ack wins and no timeout pulse is issued.
- **Counter width:** clog2(C_TIMEOUT). The counter saturates and never wraps.
- **Lock:** M_busLock is ignored in IDLE. A locked master still loses the grant on a timeout.

## Timing
- Request to grant: 1 cycle. A request sampled in IDLE at edge n gives the grant at edge n+1.
- Ack to release: 1 cycle. An ack at edge m gives OPB_MGrant=0 at m+1.
  - The earliest re-grant is m+2; one idle turnaround cycle is mandatory.
  - Exception: the park mode described under Configuration.
- Locked continuation: zero dead cycles. The grant is held continuously.
- Timeout: OPB_timeout rises C_TIMEOUT cycles after the first BUSY cycle, not counting cycles with Sl_toutSup high.
- Reset asserted mid-transfer: all outputs clear asynchronously. After deassertion, arbitration restarts from master 0.

## Configuration
- **OPB_ARB_PARK_EN defined:**
  - In IDLE, OPB_MGrant stays at onehot(arb_last); OPB_select stays 0.
  - If the parked master is the only requester, the arbiter enters BUSY in the same cycle with zero grant latency: OPB_select goes high at the next edge and the counter starts.
  - If any other master requests, the parked grant drops and the normal round-robin pick applies.
  - Reset still clears OPB_MGrant to 0.
- **OPB_ARB_PARK_EN undefined:** OPB_MGrant is 0 whenever the state is IDLE.

## Structure
- **Package opb_arb_pkg:**
  - state enum (IDLE, BUSY)
  - constants for the maximum master count and the default timeout
  - the helper function computing clog2-sized index widths
- **Sub-module opb_rr_pick:** a purely combinational round-robin priority encoder.
  - Inputs: request vector and last index.
  - Outputs: winner index and a valid flag.
- **Top:** the state machine, counter and output registers.

## Test plan
- Reset, then M_request=4'b0101 held with an ack every transfer: grants alternate 0,2,0,2. Each grant lasts until its ack, with one dead cycle between grants.
- Master 1 requests with M_busLock=1 over 3 transfers (ack every 2 cycles): OPB_MGrant stays 4'b0010 with no gap. After the lock drops, the grant is released one cycle after the final ack.
- Grant master 3 and never ack, C_TIMEOUT=16: OPB_timeout pulses once, 16 cycles after the first BUSY cycle, and the grant is 0 that same cycle.
- Same as the previous scenario but with Sl_toutSup high for 5 cycles: the timeout pulse moves to cycle 21. An Sl_xferAck coincident with counter=15 gives no pulse.
- Master 2 drops its request mid-BUSY, then OPB_Rst pulses during a later grant: the grant is released without a timeout pulse. After reset, master 0 wins when all four request.
- With OPB_ARB_PARK_EN: after master 1 completes, OPB_MGrant stays 4'b0010 in IDLE. A lone re-request from master 1 raises OPB_select on the next edge.
